// File: rtl/wb_stage.sv
// Writeback stage: W pipeline register, load data extraction,
// register-file write, forwarding, load address error, trace.
module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_aluout,
  input  logic [31:0] m_mem_rdata,
  input  logic [4:0]  m_writereg,
  input  logic        m_regwrite,
  input  logic        m_memtoreg,
  input  logic [2:0]  m_load_type,
  input  logic        flush,
  input  logic        stall_w,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data,
  output logic        exc_adel,
  output logic [31:0] exc_badvaddr,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] aluout;
    logic [31:0] mem_rdata;
    logic [4:0]  writereg;
    logic        regwrite;
    logic        memtoreg;
    logic [2:0]  load_type;
  } w_t;

  w_t w;

  logic        retire;
  logic        misaligned;
  logic        wr_ok;
  logic        is_lw;
  logic        is_lb;
  logic        is_lbu;
  logic        is_lh;
  logic        is_lhu;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] result;

  assign m_ready = ~w.valid | ~stall_w;
  assign retire  = w.valid & ~stall_w;

  // flush wins over a simultaneous accept; other fields may go stale
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w    <= '0;
      w.pc <= RESET_PC;
    end else if (flush) begin
      w.valid <= 1'b0;
    end else if (m_ready) begin
      w.valid     <= m_valid;
      w.pc        <= m_pc;
      w.aluout    <= m_aluout;
      w.mem_rdata <= m_mem_rdata;
      w.writereg  <= m_writereg;
      w.regwrite  <= m_regwrite;
      w.memtoreg  <= m_memtoreg;
      w.load_type <= m_load_type;
    end
  end

  assign is_lw  = (w.load_type == 3'd0);
  assign is_lb  = (w.load_type == 3'd1);
  assign is_lbu = (w.load_type == 3'd2);
  assign is_lh  = (w.load_type == 3'd3);
  assign is_lhu = (w.load_type == 3'd4);

  always_comb begin
    ld_byte = w.mem_rdata[7:0];
    unique case (w.aluout[1:0])
      2'd0: ld_byte = w.mem_rdata[7:0];
      2'd1: ld_byte = w.mem_rdata[15:8];
      2'd2: ld_byte = w.mem_rdata[23:16];
      2'd3: ld_byte = w.mem_rdata[31:24];
    endcase
  end

  assign ld_half = w.aluout[1] ? w.mem_rdata[31:16]
                               : w.mem_rdata[15:0];

  always_comb begin
    ld_data = w.mem_rdata;
    unique case (1'b1)
      is_lb:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      is_lbu:  ld_data = {24'd0, ld_byte};
      is_lh:   ld_data = {{16{ld_half[15]}}, ld_half};
      is_lhu:  ld_data = {16'd0, ld_half};
      default: ld_data = w.mem_rdata;
    endcase
  end

  assign result = w.memtoreg ? ld_data : w.aluout;

  assign misaligned = w.memtoreg &
    (((is_lh | is_lhu) & w.aluout[0]) |
     (is_lw & (w.aluout[1:0] != 2'd0)));

  assign wr_ok = w.regwrite & (w.writereg != 5'd0) & ~misaligned;

  assign rf_we    = retire & wr_ok;
  assign rf_waddr = w.writereg;
  assign rf_wdata = result;

  assign fwd_valid = w.valid & wr_ok;
  assign fwd_reg   = w.writereg;
  assign fwd_data  = result;

  assign exc_adel     = retire & misaligned;
  assign exc_badvaddr = w.aluout;

  assign debug_wb_pc       = w.pc;
  assign debug_wb_rf_wen   = rf_we ? 4'hf : 4'h0;
  assign debug_wb_rf_wnum  = w.writereg;
  assign debug_wb_rf_wdata = result;

endmodule
